pid_motion_cntrl: RTL and testbench

PID_MOTION_CNTRL -- requirements
Module: pid_motion_cntrl

---
 rtl/pid_motion_cntrl.sv | 252 +++++++++++++++++++++++++
 tb/tb_pid_motion_cntrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_motion_cntrl.sv
// Line-following motion controller. Scans NUM_PAIRS IR sensor pairs through
// an external A2D, forms a position error and runs a PID loop. The loop
// drives a slowly ramping forward term split into left/right motor commands.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | stopped; waits for go
// SETTLE | emitters settle before the first conversion of a scan
// CNV_R  | waiting for the right-sensor conversion of pair k
// GAP    | inter-conversion wait before the next start pulse
// CNV_L  | waiting for the left-sensor conversion of pair k
// ERR    | register saturated error and its derivative
// INTG   | decimated integral update and forward ramp
// COMP   | P, I and D terms
// OUT    | motor commands
module pid_motion_cntrl #(
  parameter int          NUM_PAIRS  = 3,
  parameter int          SETTLE_CYC = 4096,
  parameter int          PAIR_CYC   = 32,
  parameter logic [7:0]  KP         = 8'h36,
  parameter logic [7:0]  KI         = 8'h50,
  parameter logic [7:0]  KD         = 8'h00,
  parameter int          INT_DEC    = 4,
  parameter logic [11:0] FWD_MAX    = 12'h700
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 d_en,
  input  logic                 cnv_cmplt,
  input  logic [11:0]          A2D_res,
  output logic                 strt_cnv,
  output logic [2:0]           chnnl,
  output logic [NUM_PAIRS-1:0] ir_en,
  output logic [7:0]           LEDs,
  output logic [10:0]          lft,
  output logic [10:0]          rht,
  output logic                 busy
);

  typedef enum logic [3:0] {
    IDLE, SETTLE, CNV_R, CNV_L, GAP, ERR, INTG, COMP, OUT
  } state_t;

  localparam logic [15:0]          SETTLE_LD = 16'(SETTLE_CYC - 1);
  localparam logic [15:0]          PAIR_LD   = 16'(PAIR_CYC - 1);
  localparam logic [15:0]          DEC_LAST  = 16'(INT_DEC - 1);
  localparam logic [1:0]           K_LAST    = 2'(NUM_PAIRS - 1);
  localparam logic [NUM_PAIRS-1:0] IR_ONE    = NUM_PAIRS'(1);

  state_t state, state_nxt;
  logic   strt_c, scan_c;

  logic [15:0]        timer;
  logic [1:0]         k;
  logic               side;       // 0: next/current conversion is right sensor
  logic signed [15:0] acc;
  logic signed [11:0] error, error_prev, derr, intgrl;
  logic [11:0]        fwd;
  logic [15:0]        dec_cnt;
  logic signed [11:0] pcomp, icomp, dcomp;
  logic signed [11:0] lft_reg, rht_reg;

  function automatic logic signed [11:0] sat12(input logic signed [19:0] v);
    if (v > 20'sd2047)
      return 12'sh7FF;
    else if (v < -20'sd2048)
      return 12'sh800;
    else
      return v[11:0];
  endfunction

  function automatic logic signed [15:0] sx12(input logic signed [11:0] v);
    return {{4{v[11]}}, v};
  endfunction

  function automatic logic signed [19:0] sx16(input logic signed [15:0] v);
    return {{4{v[15]}}, v};
  endfunction

  function automatic logic signed [19:0] sx12w(input logic signed [11:0] v);
    return {{8{v[11]}}, v};
  endfunction

  logic               timer_tc, last_pair;
  logic signed [15:0] a2d_shft;
  logic signed [11:0] err_new, derr_new;
  logic signed [15:0] intg_sum;
  logic signed [19:0] p_prod, i_prod, d_prod;
  logic signed [15:0] fwd_s, pid_sum;
  logic signed [11:0] lft_new, rht_new;

  assign timer_tc  = (timer == 16'd0);
  assign last_pair = (k == K_LAST);
  // Pair k carries binary weight 2^k so outer sensors pull harder.
  assign a2d_shft  = $signed({4'd0, A2D_res} << k);
  assign err_new   = sat12(sx16(acc));
  assign derr_new  = sat12(sx16(sx12(err_new) - sx12(error_prev)));
  assign intg_sum  = sx12(intgrl) + (sx12(error) >>> 4);
  assign p_prod    = sx12w(error)  * $signed({12'd0, KP});
  assign i_prod    = sx12w(intgrl) * $signed({12'd0, KI});
  assign d_prod    = sx12w(derr)   * $signed({12'd0, KD});
  assign fwd_s     = $signed({4'd0, fwd});
  assign pid_sum   = sx12(pcomp) + sx12(icomp) + sx12(dcomp);
  assign lft_new   = sat12(sx16(fwd_s + pid_sum));
  assign rht_new   = sat12(sx16(fwd_s - pid_sum));

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state decode and start-pulse/scan decode; dropping go aborts from anywhere.
  always_comb begin
    state_nxt = state;
    strt_c    = 1'b0;
    scan_c    = 1'b0;
    case (state)
      IDLE:   state_nxt = SETTLE;
      SETTLE: begin
        scan_c = 1'b1;
        if (timer_tc) begin
          strt_c    = 1'b1;
          state_nxt = CNV_R;
        end
      end
      CNV_R: begin
        scan_c = 1'b1;
        if (cnv_cmplt) state_nxt = GAP;
      end
      GAP: begin
        scan_c = 1'b1;
        if (timer_tc) begin
          strt_c    = 1'b1;
          state_nxt = side ? CNV_L : CNV_R;
        end
      end
      CNV_L: begin
        scan_c = 1'b1;
        if (cnv_cmplt) state_nxt = last_pair ? ERR : GAP;
      end
      ERR:     state_nxt = INTG;
      INTG:    state_nxt = COMP;
      COMP:    state_nxt = OUT;
      OUT:     state_nxt = SETTLE;
      default: state_nxt = IDLE;
    endcase
    if (!go) begin
      state_nxt = IDLE;
      strt_c    = 1'b0;
    end
  end

  // Scan timing, error accumulation and PID datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer      <= '0;
      k          <= '0;
      side       <= 1'b0;
      acc        <= '0;
      error      <= '0;
      error_prev <= '0;
      derr       <= '0;
      intgrl     <= '0;
      fwd        <= '0;
      dec_cnt    <= '0;
      pcomp      <= '0;
      icomp      <= '0;
      dcomp      <= '0;
      lft_reg    <= '0;
      rht_reg    <= '0;
    end else if (!go) begin
      // Abort: motors stop and the ramp restarts, loop history is kept.
      timer   <= '0;
      k       <= '0;
      side    <= 1'b0;
      acc     <= '0;
      fwd     <= '0;
      lft_reg <= '0;
      rht_reg <= '0;
    end else begin
      case (state)
        IDLE, OUT: begin
          timer <= SETTLE_LD;
          k     <= '0;
          side  <= 1'b0;
          acc   <= '0;
          if (state == OUT) begin
            lft_reg <= lft_new;
            rht_reg <= rht_new;
          end
        end
        SETTLE, GAP: begin
          if (!timer_tc) timer <= timer - 16'd1;
        end
        CNV_R: begin
          if (cnv_cmplt) begin
            acc   <= acc + a2d_shft;
            side  <= 1'b1;
            timer <= PAIR_LD;
          end
        end
        CNV_L: begin
          if (cnv_cmplt) begin
            acc <= acc - a2d_shft;
            if (!last_pair) begin
              k     <= k + 2'd1;
              side  <= 1'b0;
              timer <= PAIR_LD;
            end
          end
        end
        ERR: begin
          error      <= err_new;
          derr       <= derr_new;
          error_prev <= err_new;
        end
        INTG: begin
          if (dec_cnt == DEC_LAST) begin
            dec_cnt <= '0;
            intgrl  <= sat12(sx16(intg_sum));
            if (fwd < FWD_MAX) fwd <= fwd + 12'd1;
          end else begin
            dec_cnt <= dec_cnt + 16'd1;
          end
        end
        COMP: begin
          pcomp <= sat12(p_prod >>> 8);
          icomp <= sat12(i_prod >>> 8);
          dcomp <= d_en ? sat12(d_prod >>> 8) : 12'sd0;
        end
        default: ;
      endcase
    end
  end

  // Motor commands drop the LSB of the 12-bit result.
  logic unused_lsb;
  assign unused_lsb = ^{lft_reg[0], rht_reg[0]};

  assign strt_cnv = strt_c & ~rst;
  assign chnnl    = rst ? 3'd0 : {k, side};
  assign ir_en    = (scan_c && !rst) ? (IR_ONE << k) : '0;
  assign LEDs     = rst ? 8'd0 : error[11:4];
  assign lft      = rst ? 11'd0 : lft_reg[11:1];
  assign rht      = rst ? 11'd0 : rht_reg[11:1];
  assign busy     = (state != IDLE) && !rst;

endmodule

// File: tb/tb_pid_motion_cntrl.sv
// Randomized bench for pid_motion_cntrl with a whole-scan arithmetic model.
module tb_pid_motion_cntrl;
  localparam int NP   = 3;
  localparam int SC   = 24;
  localparam int PC   = 5;
  localparam int KPI  = 'h36;
  localparam int KII  = 'hFF;
  localparam int KDI  = 'h80;
  localparam int IDEC = 2;
  localparam int FMAX = 10;

  logic          clk = 1'b0;
  logic          rst, go, d_en, cnv_cmplt;
  logic [11:0]   A2D_res;
  logic          strt_cnv;
  logic [2:0]    chnnl;
  logic [NP-1:0] ir_en;
  logic [7:0]    LEDs;
  logic [10:0]   lft, rht;
  logic          busy;

  pid_motion_cntrl #(
    .NUM_PAIRS(NP), .SETTLE_CYC(SC), .PAIR_CYC(PC),
    .KP(8'(KPI)), .KI(8'(KII)), .KD(8'(KDI)),
    .INT_DEC(IDEC), .FWD_MAX(12'(FMAX))
  ) dut (
    .clk(clk), .rst(rst), .go(go), .d_en(d_en), .cnv_cmplt(cnv_cmplt),
    .A2D_res(A2D_res), .strt_cnv(strt_cnv), .chnnl(chnnl), .ir_en(ir_en),
    .LEDs(LEDs), .lft(lft), .rht(rht), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one call per completed scan.
  int scan_v[8];
  int m_err, m_prev, m_derr, m_intg, m_fwd, m_dec, m_lft, m_rht;

  function automatic int sat(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  task automatic model_clear(input bit full);
    m_fwd = 0; m_lft = 0; m_rht = 0;
    if (full) begin
      m_err = 0; m_prev = 0; m_derr = 0; m_intg = 0; m_dec = 0;
    end
  endtask

  task automatic model_scan(input bit de);
    int acc, p, i, d;
    acc = 0;
    for (int j = 0; j < NP; j++)
      acc += (scan_v[2*j] << j) - (scan_v[2*j+1] << j);
    m_err  = sat(acc);
    m_derr = sat(m_err - m_prev);
    m_prev = m_err;
    m_dec++;
    if (m_dec == IDEC) begin
      m_dec  = 0;
      m_intg = sat(m_intg + (m_err >>> 4));
      if (m_fwd < FMAX) m_fwd++;
    end
    p = sat((m_err * KPI) >>> 8);
    i = sat((m_intg * KII) >>> 8);
    d = de ? sat((m_derr * KDI) >>> 8) : 0;
    m_lft = sat(m_fwd + p + i + d);
    m_rht = sat(m_fwd - p - i - d);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_strt(output int cyc);
    cyc = 0;
    do begin
      step();
      cnv_cmplt = 1'b0;
      A2D_res   = 12'($urandom);
      cyc++;
    end while (strt_cnv !== 1'b1 && cyc < 500);
    if (strt_cnv !== 1'b1) chk("strt_timeout", 32'(strt_cnv), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; go = 1'b0;
    repeat (2) step();
    rst = 1'b0;
    step();
    model_clear(1'b1);
  endtask

  task automatic rand_vals();
    int mode;
    mode = $urandom_range(0, 2);
    for (int c = 0; c < 8; c++) begin
      case (mode)
        0:       scan_v[c] = $urandom_range(0, 4095);
        1:       scan_v[c] = 'h7C0 + $urandom_range(0, 127);
        default: scan_v[c] = $urandom_range(0, 300);
      endcase
    end
  endtask

  // One scan; stop_ch >= 0 aborts (go drop or reset) while waiting on that channel.
  task automatic run_scan(input bit first, input bit de, input int stop_ch, input bit by_rst);
    int cyc, lat;
    d_en = de;
    for (int ch = 0; ch < 2*NP; ch++) begin
      wait_strt(cyc);
      if (ch == 0 && first)  chk("settle_gap", cyc, SC);
      else if (ch == 0)      chk("rescan_gap", cyc, SC - 1);
      else                   chk("pair_gap", cyc, PC);
      chk("chnnl", 32'(chnnl), ch);
      chk("ir_en", 32'(ir_en), 1 << (ch/2));
      cnv_cmplt = 1'($urandom_range(0, 1));
      step();
      cnv_cmplt = 1'b0;
      if (ch == stop_ch) begin
        step();
        if (by_rst) rst = 1'b1; else go = 1'b0;
        step();
        chk("abort_busy", 32'(busy), 0);
        chk("abort_strt", 32'(strt_cnv), 0);
        chk("abort_ir", 32'(ir_en), 0);
        chk("abort_lft", 32'(lft), 0);
        chk("abort_rht", 32'(rht), 0);
        if (by_rst) begin
          chk("rst_leds", 32'(LEDs), 0);
          model_clear(1'b1);
          step();
          rst = 1'b0; go = 1'b0;
        end else begin
          chk("abort_leds", 32'(LEDs), (m_err & 'hFFF) >> 4);
          chk("abort_intg", 32'($unsigned(dut.intgrl)), m_intg & 'hFFF);
          model_clear(1'b0);
        end
        return;
      end
      lat = $urandom_range(0, 3);
      repeat (lat) begin
        A2D_res = 12'($urandom);
        step();
      end
      chk("ir_hold", 32'(ir_en), 1 << (ch/2));
      cnv_cmplt = 1'b1;
      A2D_res   = 12'(scan_v[ch]);
    end
    repeat (5) begin
      step();
      cnv_cmplt = 1'b0;
    end
    model_scan(de);
    chk("lft", 32'(lft), (m_lft & 'hFFF) >> 1);
    chk("rht", 32'(rht), (m_rht & 'hFFF) >> 1);
    chk("leds", 32'(LEDs), (m_err & 'hFFF) >> 4);
    chk("fwd", 32'(dut.fwd), m_fwd);
    chk("busy_run", 32'(busy), 1);
  endtask

  initial begin
    rst = 1'b1; go = 1'b0; d_en = 1'b0; cnv_cmplt = 1'b0; A2D_res = '0;
    for (int c = 0; c < 8; c++) scan_v[c] = 0;
    model_clear(1'b1);

    repeat (2) step();
    chk("rst_strt", 32'(strt_cnv), 0);
    chk("rst_ir", 32'(ir_en), 0);
    chk("rst_lft", 32'(lft), 0);
    chk("rst_rht", 32'(rht), 0);
    chk("rst_leds", 32'(LEDs), 0);
    chk("rst_busy", 32'(busy), 0);
    go = 1'b1;
    step();
    chk("rst_prio", 32'(busy), 0);
    rst = 1'b0; go = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 0);

    // Balanced sensors.
    for (int c = 0; c < 8; c++) scan_v[c] = 'h100;
    go = 1'b1;
    for (int s = 0; s < IDEC; s++) run_scan(s == 0, 1'b0, -1, 1'b0);
    chk("bal_fwd", 32'(dut.fwd), 1);
    chk("bal_leds", 32'(LEDs), 0);
    chk("bal_lft", 32'(lft), 0);
    chk("bal_rht", 32'(rht), 0);

    // Derivative step 0 -> 0x100.
    do_reset();
    go = 1'b1;
    run_scan(1'b1, 1'b1, -1, 1'b0);
    for (int c = 0; c < 8; c++) scan_v[c] = 0;
    scan_v[0] = 'h100;
    run_scan(1'b0, 1'b1, -1, 1'b0);
    chk("d_step_lft", 32'(lft), 99);
    chk("d_step_rht", 32'(rht), 'h79E);
    run_scan(1'b0, 1'b1, -1, 1'b0);
    chk("d_hold_lft", 32'(lft), 35);
    chk("d_hold_rht", 32'(rht), 'h7DE);

    // Saturation with integral wind-up.
    do_reset();
    for (int c = 0; c < 8; c++) scan_v[c] = 0;
    scan_v[0] = 'hFFF;
    go = 1'b1;
    for (int s = 0; s < 30; s++) begin
      run_scan(s == 0, 1'b0, -1, 1'b0);
      if (s == 0) chk("sat_leds", 32'(LEDs), 'h7F);
    end
    chk("sat_lft", 32'(lft), 'h3FF);
    chk("sat_rht", 32'(rht), 'h400);

    // Randomized scans.
    for (int s = 0; s < 20; s++) begin
      rand_vals();
      run_scan(1'b0, 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    // go dropped while waiting on channel 3, stray completion while idle.
    rand_vals();
    run_scan(1'b0, 1'b1, 3, 1'b0);
    cnv_cmplt = 1'b1;
    step();
    cnv_cmplt = 1'b0;
    chk("idle_stray", 32'(busy), 0);
    go = 1'b1;
    for (int s = 0; s < 3; s++) begin
      rand_vals();
      run_scan(s == 0, 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    // Reset asserted mid-scan.
    rand_vals();
    run_scan(1'b0, 1'b0, 4, 1'b1);
    go = 1'b1;
    for (int s = 0; s < 3; s++) begin
      rand_vals();
      run_scan(s == 0, 1'($urandom_range(0, 1)), -1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
